// File: rtl/fpdiv_pkg.sv
// rtl/fpdiv_pkg.sv - shared types and constants for the binary32 divider
// Purpose : operand field layout, operand classes, FSM states and divider constants.
package fpdiv_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_e;

  typedef enum logic [1:0] {IDLE, DIV, ROUND} fpdiv_state_e;

  localparam int          BIAS      = 127;
  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam logic [31:0] POS_INF   = 32'h7F800000;
  localparam int          DIV_ITERS = 26;

endpackage

// File: rtl/fpdiv_unpack.sv
// rtl/fpdiv_unpack.sv - classify one binary32 operand and normalize its significand
// Purpose : split an operand into class, 24-bit significand (MSB set for finite
//           nonzero values) and signed biased exponent.
// Ports   : i_op    - raw binary32 operand
//           o_class - ZERO/SUB/NORM/INF/NAN
//           o_sig   - significand, 1.23 format
//           o_exp   - signed 10-bit biased exponent matching o_sig
// Config  : FPDIV_SUBNORMAL_EN - normalize subnormals with a leading-zero count;
//           when undefined, subnormals are reported as ZERO.
module fpdiv_unpack
  import fpdiv_pkg::*;
(
  input  logic [31:0]       i_op,
  output fp_class_e         o_class,
  output logic [23:0]       o_sig,
  output logic signed [9:0] o_exp
);

  fp32_t w_op;
  assign w_op = i_op;

`ifdef FPDIV_SUBNORMAL_EN
  // Leading zeros of {1'b0, frac}; the highest set bit wins because it is visited last.
  logic [4:0] w_lz;
  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (w_op.frac[i]) w_lz = 5'(23 - i);
    end
  end
`endif

  always_comb begin
    o_class = NORM;
    o_sig   = {1'b1, w_op.frac};
    o_exp   = $signed({2'b00, w_op.exp});
    if (w_op.exp == 8'hFF) begin
      o_class = (w_op.frac != 23'd0) ? NAN : INF;
      o_sig   = 24'd0;
      o_exp   = 10'sd0;
    end else if (w_op.exp == 8'h00) begin
      o_class = ZERO;
      o_sig   = 24'd0;
      o_exp   = 10'sd0;
`ifdef FPDIV_SUBNORMAL_EN
      if (w_op.frac != 23'd0) begin
        // frac * 2^-149 == (frac << lz) * 2^-23 * 2^((1 - lz) - 127)
        o_class = SUB;
        o_sig   = {1'b0, w_op.frac} << w_lz;
        o_exp   = 10'sd1 - $signed({5'b00000, w_lz});
      end
`endif
    end
  end

endmodule

// File: rtl/fpdiv.sv
// rtl/fpdiv.sv - sequential radix-2 restoring binary32 divider with RNE rounding
// Purpose : result = a / b, fixed 27-cycle latency from the accepting edge.
// Ports   : clk, rst_n (async, active-low)
//           start - request, taken while idle or in the final (ROUND) cycle
//           a, b  - dividend / divisor, sampled at the accepting edge
//           result - registered quotient, held until the next completion
//           done  - one-cycle completion pulse
//           busy  - operation in flight
// Config  : FPDIV_SUBNORMAL_EN - gradual underflow (subnormal inputs and outputs);
//           when undefined, subnormal inputs and outputs flush to signed zero.
module fpdiv
  import fpdiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  fp_class_e         w_cls_a, w_cls_b;
  logic [23:0]       w_sig_a, w_sig_b;
  logic signed [9:0] w_exp_a, w_exp_b;

  fpdiv_unpack u_unpack_a (.i_op(a), .o_class(w_cls_a), .o_sig(w_sig_a), .o_exp(w_exp_a));
  fpdiv_unpack u_unpack_b (.i_op(b), .o_class(w_cls_b), .o_sig(w_sig_b), .o_exp(w_exp_b));

  fpdiv_state_e      r_state, w_state_nxt;
  logic [4:0]        r_cnt;
  logic [24:0]       r_rem;
  logic [23:0]       r_div;
  logic [25:0]       r_quo;
  logic signed [9:0] r_exp;
  logic              r_sign;
  logic              r_special;
  logic [31:0]       r_special_val;
  logic [31:0]       r_result;
  logic              r_done;

  logic              w_accept;
  logic              w_sign;
  logic              w_special;
  logic [31:0]       w_special_val;

  // The ROUND cycle frees the datapath, so a new request can start there back-to-back.
  assign w_accept = start && ((r_state == IDLE) || (r_state == ROUND));
  assign w_sign   = a[31] ^ b[31];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = DIV;
      DIV:     if (r_cnt == 5'(DIV_ITERS - 1)) w_state_nxt = ROUND;
      ROUND:   w_state_nxt = start ? DIV : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- special operands ----------------
  always_comb begin
    w_special     = 1'b1;
    w_special_val = QNAN;
    if (w_cls_a == NAN || w_cls_b == NAN) begin
      w_special_val = QNAN;
    end else if ((w_cls_a == ZERO && w_cls_b == ZERO) || (w_cls_a == INF && w_cls_b == INF)) begin
      w_special_val = QNAN;
    end else if (w_cls_a == INF || w_cls_b == ZERO) begin
      w_special_val = POS_INF | {w_sign, 31'd0};
    end else if (w_cls_a == ZERO || w_cls_b == INF) begin
      w_special_val = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // ---------------- restoring divide step ----------------
  logic [25:0] w_diff;
  logic        w_ge;
  logic [24:0] w_rem_sel;

  assign w_diff    = {1'b0, r_rem} - {2'b00, r_div};
  assign w_ge      = ~w_diff[25];
  assign w_rem_sel = w_ge ? w_diff[24:0] : r_rem;

  // ---------------- normalize / denormalize / round ----------------
  logic [25:0]       w_n, w_dn;
  logic signed [9:0] w_exp1, w_exp_r;
  logic              w_sub, w_lost, w_guard, w_stk, w_rup;
  logic [23:0]       w_mant;
  logic [24:0]       w_mant_r;
  logic [31:0]       w_res;
`ifdef FPDIV_SUBNORMAL_EN
  logic [4:0]        w_shamt;
`endif

  always_comb begin
    // Quotient lies in (0.5, 2); a clear MSB means one more left shift is needed.
    w_n    = r_quo[25] ? r_quo : {r_quo[24:0], 1'b0};
    w_exp1 = r_quo[25] ? r_exp : r_exp - 10'sd1;
    w_sub  = (w_exp1 <= 10'sd0);
`ifdef FPDIV_SUBNORMAL_EN
    w_shamt = 5'd0;
    if (w_sub) w_shamt = (w_exp1 < -10'sd25) ? 5'd27 : 5'(10'sd1 - w_exp1);
    w_dn   = w_n >> w_shamt;
    w_lost = |(w_n & ~({26{1'b1}} << w_shamt));
`else
    w_dn   = w_n;
    w_lost = 1'b0;
`endif
    w_mant   = w_dn[25:2];
    w_guard  = w_dn[1];
    w_stk    = (r_rem != 25'd0) | w_dn[0] | w_lost;
    w_rup    = w_guard & (w_stk | w_mant[0]);
    w_mant_r = {1'b0, w_mant} + {24'd0, w_rup};
    w_exp_r  = w_exp1 + $signed({9'd0, w_mant_r[24]});
    if (w_sub) begin
`ifdef FPDIV_SUBNORMAL_EN
      // A rounding carry into bit 23 lands in the exponent LSB: subnormal -> min normal.
      w_res = {r_sign, 7'd0, w_mant_r[23], w_mant_r[22:0]};
`else
      w_res = {r_sign, 31'd0};
`endif
    end else if (w_exp_r >= 10'sd255) begin
      w_res = {r_sign, 8'hFF, 23'd0};
    end else begin
      w_res = {r_sign, w_exp_r[7:0], w_mant_r[22:0]};
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= 5'd0;
      r_rem         <= 25'd0;
      r_div         <= 24'd0;
      r_quo         <= 26'd0;
      r_exp         <= 10'sd0;
      r_sign        <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= 32'd0;
      r_result      <= 32'd0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ROUND) begin
        r_result <= r_special ? r_special_val : w_res;
        r_done   <= 1'b1;
      end
      if (w_accept) begin
        r_cnt         <= 5'd0;
        r_rem         <= {1'b0, w_sig_a};
        r_div         <= w_sig_b;
        r_quo         <= 26'd0;
        r_exp         <= w_exp_a - w_exp_b + 10'(BIAS);
        r_sign        <= w_sign;
        r_special     <= w_special;
        r_special_val <= w_special_val;
      end else if (r_state == DIV) begin
        r_cnt <= r_cnt + 5'd1;
        r_rem <= w_rem_sel << 1;
        r_quo <= {r_quo[24:0], w_ge};
      end
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_fpdiv.sv
// tb/tb_fpdiv.sv - self-checking bench for fpdiv
module tb_fpdiv;

`ifdef FPDIV_SUBNORMAL_EN
  localparam bit SUBN = 1'b1;
`else
  localparam bit SUBN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] a, b, result;
  logic        done, busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fpdiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .result(result), .done(done), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (real arithmetic on the host) ----------------
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r * 0.5;
    return r;
  endfunction

  function automatic real mag(input logic [31:0] x);
    int  e;
    real m;
    e = int'(x[30:23]);
    if (e == 0) begin m = int'(x[22:0]);          e = -149;    end
    else        begin m = int'({1'b1, x[22:0]});  e = e - 150; end
    return m * pow2(e);
  endfunction

  // 0 zero, 1 subnormal, 2 normal, 3 inf, 4 nan
  function automatic int cls(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? 4 : 3;
    if (x[30:23] == 8'h00) return (x[22:0] == 0) ? 0 : (SUBN ? 1 : 0);
    return 2;
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    int          cx, cy, fe, sh;
    logic        s;
    real         q;
    logic [63:0] bits, dm, kept, rem, half;
    cx = cls(x);
    cy = cls(y);
    s  = x[31] ^ y[31];
    if (cx == 4 || cy == 4) return 32'h7FC00000;
    if ((cx == 0 && cy == 0) || (cx == 3 && cy == 3)) return 32'h7FC00000;
    if (cx == 3 || cy == 0) return {s, 8'hFF, 23'd0};
    if (cx == 0 || cy == 3) return {s, 31'd0};
    q    = mag(x) / mag(y);
    bits = $realtobits(q);
    fe   = int'(bits[62:52]) - 1023 + 127;
    dm   = {11'd0, 1'b1, bits[51:0]};
    if (!SUBN && fe <= 0) return {s, 31'd0};
    sh = (fe >= 1) ? 29 : 30 - fe;
    if (sh > 60) sh = 60;
    kept = dm >> sh;
    rem  = dm - (kept << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
    if (fe >= 1) begin
      if (kept == 64'h1000000) begin kept = 64'h800000; fe++; end
      if (fe >= 255) return {s, 8'hFF, 23'd0};
      return {s, 8'(fe), kept[22:0]};
    end
    return {s, kept[30:0]};
  endfunction

  // ---------------- operation driver ----------------
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    lat = -1;
    res = 32'hDEADBEEF;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin lat = j; res = result; break; end
    end
  endtask

  initial begin
    logic [31:0] res;
    int          lat, ndone;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset result", result, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    vecs.push_back('{32'h7F800000, 32'h85634992, 32'hFF800000});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7F800000});
    vecs.push_back('{32'h00000000, 32'h85634992, 32'h80000000});
    vecs.push_back('{32'h7FC00000, 32'h85634993, 32'h7FC00000});
    vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000});
    vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000});
    vecs.push_back('{32'h17810000, 32'h622C0000, SUBN ? 32'h00000001 : 32'h00000000});
    vecs.push_back('{32'h958E8000, 32'hE0400000, SUBN ? 32'h00000001 : 32'h00000000});
    vecs.push_back('{32'h00005109, 32'h80034093, ref_div(32'h00005109, 32'h80034093)});
    vecs.push_back('{32'h3F800000, 32'h00000001, 32'h7F800000});
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000});
    vecs.push_back('{32'h3F800000, 32'hFF800000, 32'h80000000});
    vecs.push_back('{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000});
    vecs.push_back('{32'h00800000, 32'h40000000, SUBN ? 32'h00400000 : 32'h00000000});
    vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000});
    vecs.push_back('{32'h00000001, 32'h40000000, 32'h00000000});
    vecs.push_back('{32'h00000003, 32'h40000000, SUBN ? 32'h00000002 : 32'h00000000});
    vecs.push_back('{32'h00FFFFFF, 32'h40000000, SUBN ? 32'h00800000 : 32'h00000000});
    vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000});

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d %08h/%08h", i, vecs[i].a, vecs[i].b), res, vecs[i].y);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd27);
    end

    // start while busy is ignored; latency and result belong to the first request
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy after accept", {31'd0, busy}, 32'd1);
    lat = -1; ndone = 0; res = 32'hDEADBEEF;
    for (int j = 1; j <= 45; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = j; res = result;
          check("busy low with done", {31'd0, busy}, 32'd0);
        end
      end
      start = (j == 9);
      if (j == 9) begin a = 32'd0; b = 32'd0; end
    end
    check("ignored start latency", 32'(lat), 32'd27);
    check("ignored start result", res, 32'h40400000);
    check("ignored start done count", 32'(ndone), 32'd1);

    // reset mid-operation
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort result", result, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no done after abort", 32'(ndone), 32'd0);
    run_op(32'h3F800000, 32'h40400000, res, lat);
    check("post-reset result", res, 32'h3EAAAAAB);
    check("post-reset latency", 32'(lat), 32'd27);

    // random normals against the host model
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      end else begin
        ra = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        rb = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      end
      run_op(ra, rb, res, lat);
      check($sformatf("rand %08h/%08h", ra, rb), res, ref_div(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
